// File: rtl/weight_loader.sv
// Purpose : streams weight words from a valid/ready source into the neuron array's
//           shared write port, neuron 0 addr 0..P-1, then neuron 1, and so on.
// Latency : a beat at cycle t appears on wen/wsel/waddr/wdata at t+1; done rides the last write.
// Backpr. : s_ready is high only in LOAD with abort low; one beat per cycle at full rate.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   start, abort     begin a full load (IDLE only) / cancel back to IDLE without done
//   s_valid/s_ready  source handshake, s_data is the weight word
//   waddr/wdata/wen  registered synapse write to the neurons
//   wsel             registered one-hot neuron select, zero whenever wen is low
//   busy             high in LOAD and DONE
//   done             single-cycle completion pulse, coincident with the final write
module weight_loader #(
    parameter int NUM_NEURONS        = 100,
    parameter int PREV_LAYER_NEURONS = 784,
    parameter int WEIGHT_WIDTH       = 32,
    parameter int ADDR_WIDTH         = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [WEIGHT_WIDTH-1:0] s_data,
    output logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   waddr,
    output logic [WEIGHT_WIDTH-1:0] wdata,
    output logic                    wen,
    output logic [NUM_NEURONS-1:0]  wsel,
    output logic                    busy,
    output logic                    done
);

    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(PREV_LAYER_NEURONS - 1);
    localparam logic [NW-1:0]         NEU_LAST  = NW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [NW-1:0]         neu_cnt;
    logic                  beat;
    logic                  addr_last;
    logic                  final_beat;
    logic                  clr_cnt;

    assign beat       = s_valid && s_ready;
    assign addr_last  = (addr_cnt == ADDR_LAST);
    assign final_beat = beat && addr_last && (neu_cnt == NEU_LAST);

    // Counters restart on an accepted start and on any abort, so a new load
    // always begins at neuron 0, address 0.
    assign clr_cnt = ((state == IDLE) && start && !abort) ||
                     ((state != IDLE) && abort);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort has priority over start and over the final beat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !abort) state_nxt = LOAD;
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (final_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; done is suppressed when the DONE cycle is aborted
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            LOAD: begin
                s_ready = !abort;
                busy    = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = !abort;
            end
            default: ;
        endcase
    end

    // Address / neuron counters. The final beat wraps both to zero.
    always_ff @(posedge clk) begin
        if (!rstn || clr_cnt) begin
            addr_cnt <= '0;
            neu_cnt  <= '0;
        end else if (beat) begin
            if (addr_last) begin
                addr_cnt <= '0;
                neu_cnt  <= (neu_cnt == NEU_LAST) ? '0 : neu_cnt + 1'b1;
            end else begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    // Registered write port. waddr/wdata hold between beats; wen/wsel drop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            waddr <= '0;
            wdata <= '0;
            wen   <= 1'b0;
            wsel  <= '0;
        end else if (beat) begin
            waddr <= addr_cnt;
            wdata <= s_data;
            wen   <= 1'b1;
            wsel  <= NUM_NEURONS'(1) << neu_cnt;
        end else begin
            wen   <= 1'b0;
            wsel  <= '0;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Purpose : self-checking bench for weight_loader with a small 3x4 configuration.
// Latency : the reference model predicts every output one cycle ahead from beat counts.
// Backpr. : source stalls are randomized; the loader's s_ready is checked every cycle.
module tb_weight_loader;

    localparam int N     = 3;
    localparam int P     = 4;
    localparam int WW    = 32;
    localparam int AW    = 10;
    localparam int TOTAL = N * P;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_DONE = 2;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          abort;
    logic          s_valid;
    logic [WW-1:0] s_data;
    logic          s_ready;
    logic [AW-1:0] waddr;
    logic [WW-1:0] wdata;
    logic          wen;
    logic [N-1:0]  wsel;
    logic          busy;
    logic          done;

    weight_loader #(
        .NUM_NEURONS       (N),
        .PREV_LAYER_NEURONS(P),
        .WEIGHT_WIDTH      (WW),
        .ADDR_WIDTH        (AW)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .abort  (abort),
        .s_valid(s_valid),
        .s_data (s_data),
        .s_ready(s_ready),
        .waddr  (waddr),
        .wdata  (wdata),
        .wen    (wen),
        .wsel   (wsel),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: load phase, beats accepted in this load, and the
    // write expected on the port after the coming edge.
    int            m_phase;
    int            m_beats;
    logic          e_wen;
    logic [N-1:0]  e_wsel;
    logic [AW-1:0] e_waddr;
    logic [WW-1:0] e_wdata;
    int            e_dones;
    int            o_dones;

    logic [WW-1:0] ref_mem [N][P];
    logic [WW-1:0] obs_mem [N][P];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model.
    task automatic step(input logic v, input logic [WW-1:0] d,
                        input logic st, input logic ab, input logic rst);
        logic bt;
        int   n;
        int   a;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        start   = st;
        abort   = ab;
        rstn    = !rst;
        #1;
        chk("s_ready", s_ready, (m_phase == PH_LOAD) && !ab);
        chk("busy",    busy,    m_phase != PH_IDLE);
        chk("done",    done,    (m_phase == PH_DONE) && !ab);
        chk("wen",     wen,     e_wen);
        chk("wsel",    wsel,    e_wsel);
        chk("waddr",   waddr,   e_waddr);
        chk("wdata",   wdata,   e_wdata);
        if (done === 1'b1) o_dones++;
        if ((m_phase == PH_DONE) && !ab) e_dones++;
        if (wen === 1'b1) begin
            for (int i = 0; i < N; i++)
                if (wsel[i] === 1'b1 && int'(waddr) < P) obs_mem[i][waddr] = wdata;
        end

        if (rst) begin
            m_phase = PH_IDLE;
            m_beats = 0;
            e_wen   = 1'b0;
            e_wsel  = '0;
            e_waddr = '0;
            e_wdata = '0;
        end else begin
            bt = v && (m_phase == PH_LOAD) && !ab;
            if (bt) begin
                n = m_beats / P;
                a = m_beats % P;
                e_wen   = 1'b1;
                e_wsel  = N'(1) << n;
                e_waddr = AW'(a);
                e_wdata = d;
                ref_mem[n][a] = d;
                m_beats++;
            end else begin
                e_wen  = 1'b0;
                e_wsel = '0;
            end
            case (m_phase)
                PH_IDLE: if (st && !ab) begin
                    m_phase = PH_LOAD;
                    m_beats = 0;
                end
                PH_LOAD: begin
                    if (ab) begin
                        m_phase = PH_IDLE;
                        m_beats = 0;
                    end else if (bt && m_beats == TOTAL) begin
                        m_phase = PH_DONE;
                        m_beats = 0;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic mem_check(input string tag);
        for (int n = 0; n < N; n++)
            for (int a = 0; a < P; a++)
                chk($sformatf("%s_mem[%0d][%0d]", tag, n, a), obs_mem[n][a], ref_mem[n][a]);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int n = 0; n < N; n++)
            for (int a = 0; a < P; a++) begin
                ref_mem[n][a] = '0;
                obs_mem[n][a] = '0;
            end
        m_phase = PH_IDLE;
        m_beats = 0;
        e_wen   = 1'b0;
        e_wsel  = '0;
        e_waddr = '0;
        e_wdata = '0;
        e_dones = 0;
        o_dones = 0;

        // Reset with junk on the inputs; reset must override them.
        rstn    = 1'b0;
        start   = 1'b1;
        abort   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Test 1: back-to-back full load, data 0x100..0x10B.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("t1_done_count", o_dones, 1);
        mem_check("t1");

        // Test 2: alternating valid with random extra bubbles.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TOTAL; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
            step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
        end
        idle(2);
        mem_check("t2");

        // Test 3: abort after 6 beats (valid held high in the abort cycle),
        // then a restart; this load is aborted in its DONE cycle.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        mem_check("t3");

        // Test 4: reset asserted during beat 5, then a complete reload.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        idle(2);
        mem_check("t4");

        // Test 5: start during LOAD and DONE is ignored; start in the cycle
        // after DONE is taken; start+abort together in IDLE stays IDLE.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b1, $urandom, (i % 3) == 1, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TOTAL; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        idle(3);
        mem_check("t5");
        chk("total_done_count", o_dones, e_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
